pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised successor to the PC input adapter: the next-PC mux plus the PC register itself.
- Adds stall, halt, a single-level interrupt with EPC save/ERET return, and a saturating counter of PC updates.
- Sits at the head of the single-cycle MIPS datapath, feeding instruction-memory address and pc_plus4 to the link-register write path.

Parameters:
ADDR_BITS, 32, PC width; must be >= 28.
RESET_VECTOR, 32'h0000_0000, PC value after reset; word aligned.
IRQ_VECTOR, 32'h0000_0800, handler entry address; word aligned.
CNT_BITS, 32, width of the update counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hold PC and all state this cycle.
pcsel  in  1  conditional branch taken.
Jmp  in  1  J/JAL.
Jr  in  1  JR/JALR.
halt  in  1  halt request (syscall exit).
irq  in  1  interrupt request, level.
eret  in  1  return from interrupt.
imm_16  in  16  branch offset, words, signed.
imm_26  in  26  jump target index.
regfile_out1  in  ADDR_BITS  JR target.
pc  out  ADDR_BITS  current PC.
pc_plus4  out  ADDR_BITS  pc + 4.
epc  out  ADDR_BITS  saved return PC.
halted  out  1  in HALT state.
in_isr  out  1  in ISR state.
redirect  out  1  registered pulse: last update was non-sequential.
upd_cnt  out  CNT_BITS  number of PC updates since reset.

Behaviour:
- Reset values on rst at a clock edge: pc=RESET_VECTOR, epc=0, state=RUN, redirect=0, upd_cnt=0. Reset overrides everything, including mid-ISR and HALT.
- pc_plus4 is combinational: pc+4, modulo 2^ADDR_BITS, wraps silently.
- Targets, all mod 2^ADDR_BITS:
  - br_t = pc_plus4 + (sign_extend(imm_16) << 2)
  - j_t = {pc_plus4[ADDR_BITS-1:28], imm_26, 2'b00}
  - jr_t = regfile_out1, used unmasked; misaligned values pass through.
- States: RUN, ISR, HALT. halted = (state==HALT); in_isr = (state==ISR).
- Per-edge priority, highest first:
  1. rst.
  2. state==HALT: hold everything, no counting; exit only via rst.
  3. stall: hold pc, epc, state and upd_cnt; redirect<=0. halt, irq and eret are ignored that cycle.
  4. halt: state->HALT, pc held, redirect<=0.
  5. irq && state==RUN: epc<=next-PC (the value computed by rules 7-10), pc<=IRQ_VECTOR, state->ISR, redirect<=1.
  6. eret && state==ISR: pc<=epc, state->RUN, redirect<=1. eret in RUN is ignored and falls through to rule 7.
  7. Jr: pc<=jr_t.
  8. Jmp: pc<=j_t.
  9. pcsel: pc<=br_t.
  10. otherwise: pc<=pc_plus4.
- redirect <= 1 for rules 5-9, 0 for rule 10.
- Interrupt masking: irq is masked while in ISR; nesting is not supported. If irq is still high after eret, it is taken on the next unstalled RUN cycle.
- upd_cnt increments on every edge where pc is written by rules 5-10. It saturates at all-ones.
- Single-cycle latency: decisions take effect at the next rising edge. No combinational path from irq, halt or eret to pc.

Test Plan:
- Reset then 3 idle cycles -> pc 0,4,8,12; redirect=0; upd_cnt=3.
- pc=4, pcsel=1, imm_16=16'h0001 -> pc=12. pc=4, imm_16=16'hffff -> pc=4, redirect=1.
- pc=4, Jmp=1, imm_26=26'h3ffffff -> pc=32'h0fff_fffc. Then Jr=1 and Jmp=1, regfile_out1=4 -> pc=4 (Jr wins).
- pc=8, irq=1 with Jmp=1, imm_26=1 -> epc=4, pc=32'h800, in_isr=1. A second irq in ISR is ignored. eret -> pc=4, in_isr=0.
- stall=1 with irq=1 and halt=1 for 2 cycles -> pc and upd_cnt unchanged. Release stall with halt=1 -> halted=1; pc frozen for 5 cycles despite Jmp and irq.
- rst asserted mid-ISR -> pc=RESET_VECTOR, epc=0, in_isr=0. CNT_BITS=2 with 5 updates -> upd_cnt stays at 3.

Source files
------------

// File: rtl/pc_unit.sv
// PC register and next-PC selection for the single-cycle MIPS datapath.
// Adds stall, halt, one-level interrupt with EPC/ERET and an update counter.
module pc_unit #(
  parameter int unsigned ADDR_BITS = 32,
  parameter logic [ADDR_BITS-1:0] RESET_VECTOR = ADDR_BITS'(32'h0000_0000),
  parameter logic [ADDR_BITS-1:0] IRQ_VECTOR = ADDR_BITS'(32'h0000_0800),
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 pcsel,
  input  logic                 Jmp,
  input  logic                 Jr,
  input  logic                 halt,
  input  logic                 irq,
  input  logic                 eret,
  input  logic [15:0]          imm_16,
  input  logic [25:0]          imm_26,
  input  logic [ADDR_BITS-1:0] regfile_out1,
  output logic [ADDR_BITS-1:0] pc,
  output logic [ADDR_BITS-1:0] pc_plus4,
  output logic [ADDR_BITS-1:0] epc,
  output logic                 halted,
  output logic                 in_isr,
  output logic                 redirect,
  output logic [CNT_BITS-1:0]  upd_cnt
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_ISR  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [ADDR_BITS-1:0] LO_MASK =
    ADDR_BITS'(28'hfff_ffff);

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] br_t;
  logic [ADDR_BITS-1:0] j_t;
  logic [ADDR_BITS-1:0] nxt;
  logic                 nxt_jump;
  logic [CNT_BITS-1:0]  cnt_inc;

  assign pc_plus4 = pc + ADDR_BITS'(4);
  assign br_t = pc_plus4
              + ADDR_BITS'($signed({imm_16, 2'b00}));
  // Jump keeps the region bits above 28 from pc_plus4
  assign j_t = (pc_plus4 & ~LO_MASK)
             | ADDR_BITS'({imm_26, 2'b00});

  always_comb begin
    nxt      = pc_plus4;
    nxt_jump = 1'b1;
    priority case (1'b1)
      Jr:      nxt = regfile_out1;
      Jmp:     nxt = j_t;
      pcsel:   nxt = br_t;
      default: nxt_jump = 1'b0;
    endcase
  end

  assign cnt_inc = (&upd_cnt) ? upd_cnt
                 : upd_cnt + CNT_BITS'(1);

  assign halted = (state == S_HALT);
  assign in_isr = (state == S_ISR);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      epc      <= '0;
      state    <= S_RUN;
      redirect <= 1'b0;
      upd_cnt  <= '0;
    end else if (state == S_HALT) begin
      pc <= pc;
    end else if (stall) begin
      redirect <= 1'b0;
    end else if (halt) begin
      state    <= S_HALT;
      redirect <= 1'b0;
    end else if (irq && state == S_RUN) begin
      epc      <= nxt;
      pc       <= IRQ_VECTOR;
      state    <= S_ISR;
      redirect <= 1'b1;
      upd_cnt  <= cnt_inc;
    end else if (eret && state == S_ISR) begin
      pc       <= epc;
      state    <= S_RUN;
      redirect <= 1'b1;
      upd_cnt  <= cnt_inc;
    end else begin
      pc       <= nxt;
      redirect <= nxt_jump;
      upd_cnt  <= cnt_inc;
    end
  end

endmodule
